kyber_seq_ctrl: RTL and testbench
=================================

KYBER_SEQ_CTRL -- requirements
Module: kyber_seq_ctrl

Interface
REQ-001 SHALL have parameter PK_CHUNKS, default 50, number of 128-bit pk chunks.
REQ-002 SHALL have parameter SK_CHUNKS, default 48, number of 128-bit sk chunks.
REQ-003 SHALL have parameter C_CHUNKS, default 48, number of 128-bit c chunks.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 65535, max RUN cycles before timeout.
REQ-005 SHALL have port s_axi_aclk, input, 1, sole clock (all logic on rising edge).
REQ-006 SHALL have port s_axi_aresetn, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port start, input, 1, operation request (level; sampled in IDLE only).
REQ-008 SHALL have port mode, input, 2, 0 keygen, 1 encaps, 2 decaps, 3 reserved.
REQ-009 SHALL have port abort, input, 1, host abort request.
REQ-010 SHALL have port core_finish, input, 1, Kyber core completion pulse.
REQ-011 SHALL have port core_start, output, 1, one-cycle core start pulse.
REQ-012 SHALL have port buf_sel, output, 2, target buffer: 0 pk, 1 sk, 2 c.
REQ-013 SHALL have port buf_addr, output, 6, chunk index.
REQ-014 SHALL have port buf_re, output, 1, buffer read strobe (1-cycle BRAM latency).
REQ-015 SHALL have port load_valid, output, 1, read data valid (buf_re delayed 1 cycle).
REQ-016 SHALL have port buf_we, output, 1, buffer write strobe for core result chunk.
REQ-017 SHALL have ports busy, done, err, outputs, 1 each, status for host register.

Function
REQ-018 SHALL implement states IDLE, LOAD, RUN, STORE; all outputs registered.
REQ-019 In IDLE with start=1, mode 0..2: SHALL latch mode, clear done and err, set busy, go LOAD (mode 1,2) or RUN (mode 0).
REQ-020 In IDLE with start=1, mode=3: SHALL set err=1, done=0, stay IDLE, busy=0.
REQ-021 start SHALL be ignored outside IDLE; mode changes after acceptance SHALL have no effect.
REQ-022 LOAD segments: mode 1 = pk(PK_CHUNKS); mode 2 = sk(SK_CHUNKS) then c(C_CHUNKS), back-to-back, no gap cycle.
REQ-023 In LOAD, buf_re=1 every cycle, buf_addr 0..N-1 per segment, buf_sel per segment; load_valid = buf_re one cycle later.
REQ-024 Last buf_re at cycle t SHALL give load_valid at t+1 and RUN entry at t+2.
REQ-025 core_start SHALL be 1 exactly in the first RUN cycle, else 0.
REQ-026 In RUN, core_finish=1 in any cycle after the core_start cycle SHALL move to STORE (mode 0,1) or complete (mode 2); core_finish in the core_start cycle or outside RUN SHALL be ignored.
REQ-027 RUN cycle counter SHALL clear on RUN entry; if it reaches TIMEOUT_CYC without core_finish: err=1, busy=0, done=0, go IDLE.
REQ-028 STORE segments: mode 0 = pk(PK_CHUNKS) then sk(SK_CHUNKS); mode 1 = c(C_CHUNKS); buf_we=1 each cycle, buf_addr 0..N-1, back-to-back.
REQ-029 Completion (cycle after last buf_we, or cycle after core_finish in mode 2): done=1, busy=0, go IDLE; done held until next accepted start.
REQ-030 abort=1 in any non-IDLE state SHALL, next cycle: go IDLE, busy=0, done=0, err=1, buf_re/buf_we/core_start=0; abort in IDLE ignored.
REQ-031 abort and core_finish in same cycle: abort SHALL win.
REQ-032 buf_addr SHALL never exceed N-1 of the active segment; buf_sel/buf_addr SHALL hold 0 in IDLE and RUN.

Reset
REQ-033 s_axi_aresetn=0 SHALL immediately force IDLE and all outputs and counters to 0, including mid-LOAD/RUN/STORE.
REQ-034 First accepted start SHALL be possible the first clock after reset release.

Verification
REQ-035 Mode 1, start pulse -> buf_re 50 cycles addr 0..49 sel 0, core_start at +2 after last read; core_finish after 10 cycles -> 48 buf_we sel 2 addr 0..47, then done=1 busy=0.
REQ-036 Mode 2 -> 48 reads sel 1 then 48 reads sel 2 contiguous; core_finish -> no buf_we, done=1 next cycle.
REQ-037 Mode 0 -> core_start cycle after start, no reads; finish -> 50 writes sel 0 then 48 writes sel 1, done=1.
REQ-038 Mode 3 -> err=1, busy=0, no strobes; subsequent mode 1 start clears err.
REQ-039 TIMEOUT_CYC=20, core_finish withheld -> err=1, IDLE after exactly 20 RUN cycles; abort during LOAD addr 10 -> IDLE next cycle, err=1.
REQ-040 Reset asserted mid-STORE addr 5 -> all outputs 0 asynchronously; start after release runs normally.

Source files
------------

// File: rtl/kyber_seq_ctrl.sv
// Sequencing controller for a Kyber core: streams operands out of the pk/sk/c
// buffers, starts the core, and writes results back, with timeout and abort.
module kyber_seq_ctrl #(
  parameter int PK_CHUNKS   = 50,
  parameter int SK_CHUNKS   = 48,
  parameter int C_CHUNKS    = 48,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic       s_axi_aclk,
  input  logic       s_axi_aresetn,
  input  logic       start,
  input  logic [1:0] mode,
  input  logic       abort,
  input  logic       core_finish,
  output logic       core_start,
  output logic [1:0] buf_sel,
  output logic [5:0] buf_addr,
  output logic       buf_re,
  output logic       load_valid,
  output logic       buf_we,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_RUN   = 2'd2,
    S_STORE = 2'd3
  } state_e;

  localparam logic [1:0] SEL_PK   = 2'd0;
  localparam logic [1:0] SEL_SK   = 2'd1;
  localparam logic [1:0] SEL_C    = 2'd2;
  localparam logic [1:0] MODE_KG  = 2'd0;
  localparam logic [1:0] MODE_DEC = 2'd2;
  localparam logic [1:0] MODE_RSV = 2'd3;
  localparam int         CNT_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

  state_e             state_q;
  logic [1:0]         mode_q;
  logic               seg_q;
  logic               drain_q;
  logic [CNT_W-1:0]   run_cnt_q;
  logic               core_start_q;
  logic [1:0]         buf_sel_q;
  logic [5:0]         buf_addr_q;
  logic               buf_re_q;
  logic               load_valid_q;
  logic               buf_we_q;
  logic               busy_q;
  logic               done_q;
  logic               err_q;

  logic               at_last_addr_s;
  logic               at_final_seg_s;
  logic               run_timeout_s;
  logic               finish_ok_s;

  function automatic logic [5:0] last_addr(input logic [1:0] sel);
    case (sel)
      SEL_PK:  last_addr = 6'(PK_CHUNKS - 1);
      SEL_SK:  last_addr = 6'(SK_CHUNKS - 1);
      SEL_C:   last_addr = 6'(C_CHUNKS - 1);
      default: last_addr = 6'd0;
    endcase
  endfunction

  // Buffer addressed by segment `seg` of the load or store phase for mode `m`.
  function automatic logic [1:0] seg_sel(input logic is_store, input logic [1:0] m,
                                         input logic seg);
    if (is_store) begin
      if (m == MODE_KG) seg_sel = seg ? SEL_SK : SEL_PK;
      else              seg_sel = SEL_C;
    end else begin
      if (m == MODE_DEC) seg_sel = seg ? SEL_C : SEL_SK;
      else               seg_sel = SEL_PK;
    end
  endfunction

  function automatic logic final_seg(input logic is_store, input logic [1:0] m,
                                     input logic seg);
    if (is_store) final_seg = (m == MODE_KG) ? seg : 1'b1;
    else          final_seg = (m == MODE_DEC) ? seg : 1'b1;
  endfunction

  assign at_last_addr_s = (buf_addr_q == last_addr(buf_sel_q));
  assign at_final_seg_s = final_seg(state_q == S_STORE, mode_q, seg_q);
  assign run_timeout_s  = (run_cnt_q == CNT_W'(TIMEOUT_CYC - 1));
  // The core may not finish in the very cycle it is started.
  assign finish_ok_s    = core_finish && !core_start_q;

  // Sequencer state machine with all host and buffer outputs registered.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q      <= S_IDLE;
      mode_q       <= 2'd0;
      seg_q        <= 1'b0;
      drain_q      <= 1'b0;
      run_cnt_q    <= '0;
      core_start_q <= 1'b0;
      buf_sel_q    <= 2'd0;
      buf_addr_q   <= 6'd0;
      buf_re_q     <= 1'b0;
      load_valid_q <= 1'b0;
      buf_we_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      load_valid_q <= buf_re_q;
      core_start_q <= 1'b0;
      if (abort && (state_q != S_IDLE)) begin
        state_q    <= S_IDLE;
        seg_q      <= 1'b0;
        drain_q    <= 1'b0;
        run_cnt_q  <= '0;
        buf_sel_q  <= 2'd0;
        buf_addr_q <= 6'd0;
        buf_re_q   <= 1'b0;
        buf_we_q   <= 1'b0;
        busy_q     <= 1'b0;
        done_q     <= 1'b0;
        err_q      <= 1'b1;
      end else begin
        case (state_q)
          S_IDLE: begin
            seg_q      <= 1'b0;
            drain_q    <= 1'b0;
            run_cnt_q  <= '0;
            buf_sel_q  <= 2'd0;
            buf_addr_q <= 6'd0;
            buf_re_q   <= 1'b0;
            buf_we_q   <= 1'b0;
            if (start) begin
              if (mode == MODE_RSV) begin
                err_q  <= 1'b1;
                done_q <= 1'b0;
                busy_q <= 1'b0;
              end else begin
                mode_q <= mode;
                err_q  <= 1'b0;
                done_q <= 1'b0;
                busy_q <= 1'b1;
                if (mode == MODE_KG) begin
                  state_q      <= S_RUN;
                  core_start_q <= 1'b1;
                end else begin
                  state_q   <= S_LOAD;
                  buf_re_q  <= 1'b1;
                  buf_sel_q <= seg_sel(1'b0, mode, 1'b0);
                end
              end
            end
          end

          S_LOAD: begin
            // After the final read, one drain cycle lets load_valid cover it.
            if (drain_q) begin
              drain_q      <= 1'b0;
              state_q      <= S_RUN;
              core_start_q <= 1'b1;
              run_cnt_q    <= '0;
            end else if (at_last_addr_s) begin
              buf_addr_q <= 6'd0;
              if (at_final_seg_s) begin
                buf_re_q  <= 1'b0;
                buf_sel_q <= 2'd0;
                drain_q   <= 1'b1;
              end else begin
                seg_q     <= 1'b1;
                buf_sel_q <= seg_sel(1'b0, mode_q, 1'b1);
              end
            end else begin
              buf_addr_q <= buf_addr_q + 6'd1;
            end
          end

          S_RUN: begin
            if (finish_ok_s) begin
              run_cnt_q <= '0;
              if (mode_q == MODE_DEC) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                state_q    <= S_STORE;
                seg_q      <= 1'b0;
                buf_we_q   <= 1'b1;
                buf_sel_q  <= seg_sel(1'b1, mode_q, 1'b0);
                buf_addr_q <= 6'd0;
              end
            end else if (run_timeout_s) begin
              state_q   <= S_IDLE;
              run_cnt_q <= '0;
              busy_q    <= 1'b0;
              done_q    <= 1'b0;
              err_q     <= 1'b1;
            end else begin
              run_cnt_q <= run_cnt_q + CNT_W'(1);
            end
          end

          S_STORE: begin
            if (at_last_addr_s) begin
              buf_addr_q <= 6'd0;
              if (at_final_seg_s) begin
                state_q   <= S_IDLE;
                buf_we_q  <= 1'b0;
                buf_sel_q <= 2'd0;
                seg_q     <= 1'b0;
                busy_q    <= 1'b0;
                done_q    <= 1'b1;
              end else begin
                seg_q     <= 1'b1;
                buf_sel_q <= seg_sel(1'b1, mode_q, 1'b1);
              end
            end else begin
              buf_addr_q <= buf_addr_q + 6'd1;
            end
          end

          default: begin
            state_q  <= S_IDLE;
            buf_re_q <= 1'b0;
            buf_we_q <= 1'b0;
            busy_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign core_start = core_start_q;
  assign buf_sel    = buf_sel_q;
  assign buf_addr   = buf_addr_q;
  assign buf_re     = buf_re_q;
  assign load_valid = load_valid_q;
  assign buf_we     = buf_we_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_kyber_seq_ctrl.sv
// Scoreboard bench for kyber_seq_ctrl: a transaction-level model builds the
// expected per-cycle timeline of each operation; a monitor checks every event.
module tb_kyber_seq_ctrl;

  localparam int PK = 50;
  localparam int SK = 48;
  localparam int CC = 48;
  localparam int TO = 20;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [1:0] mode;
  logic       abort;
  logic       core_finish;
  logic       core_start;
  logic [1:0] buf_sel;
  logic [5:0] buf_addr;
  logic       buf_re;
  logic       load_valid;
  logic       buf_we;
  logic       busy;
  logic       done;
  logic       err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int         cyc;
    logic       re, we, cs, lv;
    logic [1:0] sel;
    logic [5:0] addr;
    logic       busy, done, err;
  } ev_t;

  ev_t  sbq[$];
  logic mb = 1'b0, md = 1'b0, me = 1'b0;
  logic [2:0] prev_st = 3'b000;

  kyber_seq_ctrl #(
    .PK_CHUNKS(PK), .SK_CHUNKS(SK), .C_CHUNKS(CC), .TIMEOUT_CYC(TO)
  ) dut (
    .s_axi_aclk(clk), .s_axi_aresetn(rst_n), .start(start), .mode(mode),
    .abort(abort), .core_finish(core_finish), .core_start(core_start),
    .buf_sel(buf_sel), .buf_addr(buf_addr), .buf_re(buf_re),
    .load_valid(load_valid), .buf_we(buf_we), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  function automatic ev_t mk(input logic re, input logic we, input logic cs,
                             input logic [1:0] sel, input int a,
                             input logic b, input logic d, input logic e);
    ev_t x;
    x.cyc = 0; x.re = re; x.we = we; x.cs = cs; x.lv = 1'b0;
    x.sel = sel; x.addr = 6'(a); x.busy = b; x.done = d; x.err = e;
    return x;
  endfunction

  // Monitor: every strobe or status change must match the next expected event.
  always @(negedge clk) begin
    ev_t  e;
    logic [2:0] st;
    logic bad;
    if (!rst_n) begin
      prev_st = 3'b000;
    end else begin
      st = {busy, done, err};
      if (buf_re || buf_we || core_start || load_valid || (st != prev_st)) begin
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event cyc=%0d re=%b we=%b cs=%b lv=%b sel=%0d addr=%0d bdr=%b (none expected)",
                   cyc, buf_re, buf_we, core_start, load_valid, buf_sel, buf_addr, st);
        end else begin
          e = sbq.pop_front();
          bad = (e.cyc != cyc) || (e.re !== buf_re) || (e.we !== buf_we) ||
                (e.cs !== core_start) || (e.lv !== load_valid) ||
                ({e.busy, e.done, e.err} !== st);
          if (e.re || e.we || e.cs || !e.busy)
            bad = bad || (e.sel !== buf_sel) || (e.addr !== buf_addr);
          if (bad) begin
            errors++;
            $display("FAIL event: actual cyc=%0d re=%b we=%b cs=%b lv=%b sel=%0d addr=%0d bdr=%b, expected cyc=%0d re=%b we=%b cs=%b lv=%b sel=%0d addr=%0d bdr=%b%b%b",
                     cyc, buf_re, buf_we, core_start, load_valid, buf_sel, buf_addr, st,
                     e.cyc, e.re, e.we, e.cs, e.lv, e.sel, e.addr, e.busy, e.done, e.err);
          end
        end
      end
      prev_st = st;
    end
  end

  task automatic check_all_zero(input string name);
    logic [16:0] v;
    v = {core_start, buf_sel, buf_addr, buf_re, load_valid, buf_we, busy, done, err};
    checks++;
    if (v !== 17'd0) begin
      errors++;
      $display("FAIL %s: outputs=%h, expected 0", name, v);
    end
  endtask

  // fin_d: RUN-cycle offset of the core_finish pulse (-1 none); abort_sel:
  // fixed cycle offset from start, -1 none, -2 random.
  task automatic run_op(input int m, input int fin_d, input bit extra0,
                        input int abort_sel, input bit do_reset, input bit nowait);
    ev_t tl[$];
    ev_t x;
    int  p, cs_c, e_c, a, rst_off, n_run, c;
    bit  eff;
    if (!nowait) @(negedge clk);
    p = cyc + 1;
    start = 1'b1;
    mode  = 2'(m);
    cs_c  = -1000;

    if (m == 3) begin
      tl.push_back(mk(0, 0, 0, 2'd0, 0, 0, 0, 1));
    end else begin
      if (m == 1) for (int i = 0; i < PK; i++) tl.push_back(mk(1, 0, 0, 2'd0, i, 1, 0, 0));
      if (m == 2) begin
        for (int i = 0; i < SK; i++) tl.push_back(mk(1, 0, 0, 2'd1, i, 1, 0, 0));
        for (int i = 0; i < CC; i++) tl.push_back(mk(1, 0, 0, 2'd2, i, 1, 0, 0));
      end
      if (m != 0) tl.push_back(mk(0, 0, 0, 2'd0, 0, 1, 0, 0));
      cs_c  = p + tl.size();
      eff   = (fin_d >= 1) && (fin_d <= TO - 1);
      n_run = eff ? fin_d + 1 : TO;
      tl.push_back(mk(0, 0, 1, 2'd0, 0, 1, 0, 0));
      for (int j = 1; j < n_run; j++) tl.push_back(mk(0, 0, 0, 2'd0, 0, 1, 0, 0));
      if (!eff) begin
        tl.push_back(mk(0, 0, 0, 2'd0, 0, 0, 0, 1));
      end else begin
        if (m == 0) begin
          for (int i = 0; i < PK; i++) tl.push_back(mk(0, 1, 0, 2'd0, i, 1, 0, 0));
          for (int i = 0; i < SK; i++) tl.push_back(mk(0, 1, 0, 2'd1, i, 1, 0, 0));
        end
        if (m == 1) for (int i = 0; i < CC; i++) tl.push_back(mk(0, 1, 0, 2'd2, i, 1, 0, 0));
        tl.push_back(mk(0, 0, 0, 2'd0, 0, 0, 1, 0));
      end
    end

    a = abort_sel;
    if (abort_sel == -2) begin
      a = -1;
      if (tl.size() >= 3 && $urandom_range(0, 3) == 0) a = $urandom_range(1, tl.size() - 2);
    end
    if (a >= 1 && a <= tl.size() - 2) begin
      while (tl.size() > a + 1) void'(tl.pop_back());
      tl.push_back(mk(0, 0, 0, 2'd0, 0, 0, 0, 1));
    end
    // load_valid is the read strobe seen one cycle late
    for (int k = tl.size() - 1; k >= 1; k--) tl[k].lv = tl[k-1].re;

    rst_off = tl.size();
    if (do_reset) begin
      for (int k = tl.size() - 1; k >= 0; k--) if (tl[k].we && tl[k].addr == 6'd5) rst_off = k;
    end

    for (int k = 0; k < tl.size() && k <= rst_off; k++) begin
      x = tl[k];
      x.cyc = p + k;
      if (x.re || x.we || x.cs || x.lv || ({x.busy, x.done, x.err} != {mb, md, me}))
        sbq.push_back(x);
      {mb, md, me} = {x.busy, x.done, x.err};
    end
    e_c = p + tl.size() - 1;

    for (int n = 0; n <= tl.size() + 2; n++) begin
      @(negedge clk);
      c = cyc;
      if (do_reset && c == p + rst_off) begin
        start = 1'b0; abort = 1'b0; core_finish = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_reset_mid_store");
        sbq.delete();
        {mb, md, me} = 3'b000;
        return;
      end
      start       = (m != 3) && (c == p + 1);
      mode        = 2'($urandom_range(0, 3));
      abort       = (c == p + a) || (c == e_c + 1);
      core_finish = (fin_d >= 0 && c == cs_c + fin_d) || (extra0 && c == cs_c) ||
                    ((m == 1 || m == 2) && c == p + 2) || (c == e_c + 2);
    end
    start = 1'b0; abort = 1'b0; core_finish = 1'b0;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL missing_events: %0d expected events never seen (next at cyc %0d), required 0",
               sbq.size(), sbq[0].cyc);
      sbq.delete();
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; mode = 2'd0; abort = 1'b0; core_finish = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset_state");
    #2 rst_n = 1'b1;
    // mode 1 accepted on the very first edge after reset release
    run_op(1, 10, 0, -1, 0, 1);
    run_op(2, 5, 0, -1, 0, 0);
    run_op(0, 3, 0, -1, 0, 0);
    run_op(3, -1, 0, -1, 0, 0);
    run_op(3, -1, 0, -1, 0, 0);
    run_op(1, 4, 0, -1, 0, 0);
    run_op(1, -1, 0, -1, 0, 0);
    run_op(0, -1, 1, -1, 0, 0);
    run_op(1, 10, 0, 10, 0, 0);
    run_op(0, 5, 0, 5, 0, 0);
    run_op(2, 19, 0, -1, 0, 0);
    run_op(2, 20, 0, -1, 0, 0);
    run_op(1, 10, 0, -1, 1, 0);
    repeat (2) @(negedge clk);
    check_all_zero("held_in_reset");
    #2 rst_n = 1'b1;
    run_op(1, 10, 0, -1, 0, 1);
    for (int t = 0; t < 14; t++) begin
      int rm, rd;
      rm = $urandom_range(0, 3);
      rd = $urandom_range(0, 23) - 1;
      run_op(rm, rd, 1'($urandom_range(0, 1)), -2, 0, 0);
    end
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
